// File: rtl/freq_meter.sv
// freq_meter: counts rising edges and high-time of an async input over a GATE_CYCLES-long clk window.
// Latency: sig_in edges reach the counters 2-3 clk later; results appear with freq_valid one clk after the final window cycle.
// Backpressure: none; freq_valid is a one-cycle strobe and the consumer must capture freq_out/high_out on it.
// Ports: clk, rst_n (async, active-low); en (level, keeps windows running back-to-back while high);
//        sig_in (async signal under test); freq_out/high_out (last completed window);
//        freq_valid (update strobe); busy (window in progress).
module freq_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_W       = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_out,
    output logic [CNT_W-1:0] high_out,
    output logic             freq_valid,
    output logic             busy
);
    localparam int            GW   = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);

    typedef enum logic {IDLE, GATE} state_t;

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic             rise, sig;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt, high_cnt;
    logic [CNT_W-1:0] edge_fin, high_fin;
    logic             last, done, clear;

    // s1/s2 resolve metastability; s3 gives the previous synchronized level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sig  = s2;
    assign rise = s2 & ~s3;
    assign last = (state == GATE) && (gate_cnt == LAST);

    // Counts including the current cycle's contribution; on the final cycle these are the results.
    assign edge_fin = edge_cnt + CNT_W'(rise);
    assign high_fin = high_cnt + CNT_W'(sig);

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = GATE;
                    clear     = 1'b1;
                end
            end
            GATE: begin
                if (last) begin
                    // Window complete: publish, then restart with no gap cycle if still enabled.
                    done      = 1'b1;
                    clear     = 1'b1;
                    state_nxt = en ? GATE : IDLE;
                end else if (!en) begin
                    // Abort: partial counts are dropped, they get cleared on the next entry.
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == GATE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            high_cnt <= '0;
        end else if (clear) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            high_cnt <= '0;
        end else if (state == GATE) begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= edge_fin;
            high_cnt <= high_fin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_out   <= '0;
            high_out   <= '0;
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= done;
            if (done) begin
                freq_out <= edge_fin;
                high_out <= high_fin;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed bench for freq_meter with GATE_CYCLES=1000.
// A history-based reference model predicts every output on every cycle; literal checks pin key results.
`timescale 1ns/1ps
module tb_freq_meter;
    localparam int G    = 1000;
    localparam int W    = 16;
    localparam int HMAX = 32768;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b1;
    logic         en     = 1'b0;
    logic         sig_in = 1'b0;
    logic [W-1:0] freq_out, high_out;
    logic         freq_valid, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sig_in     (sig_in),
        .freq_out   (freq_out),
        .high_out   (high_out),
        .freq_valid (freq_valid),
        .busy       (busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: samp[k] is sig_in seen at clk edge k. The cycle after edge c sees the
    // synchronized level samp[c-1], and a rise when samp[c-1]=1 and samp[c-2]=0. A window entered
    // at edge S spans the cycles after edges S..S+G-1 and publishes at edge S+G.
    bit samp [HMAX];
    int k = 0, rst_k = 0, s_edge = 0;
    bit in_gate = 1'b0;
    int m_freq = 0, m_high = 0;
    bit m_vld = 1'b0, m_busy = 1'b0;

    function automatic bit sv(input int i);
        return (i > rst_k) ? samp[i] : 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_k   = k;
            in_gate = 1'b0;
            m_vld   = 1'b0;
            m_busy  = 1'b0;
            m_freq  = 0;
            m_high  = 0;
        end else begin
            k       = k + 1;
            samp[k] = sig_in;
            m_vld   = 1'b0;
            if (in_gate) begin
                if (k == s_edge + G) begin
                    m_freq = 0;
                    m_high = 0;
                    for (int c = s_edge; c < k; c++) begin
                        m_high += int'(sv(c - 1));
                        m_freq += int'(sv(c - 1) && !sv(c - 2));
                    end
                    m_vld = 1'b1;
                    if (en) s_edge = k;
                    else    in_gate = 1'b0;
                end else if (!en) begin
                    in_gate = 1'b0;
                end
            end else if (en) begin
                in_gate = 1'b1;
                s_edge  = k;
            end
            m_busy = in_gate;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // mode 0: square wave (period p1 before w=sw, p2 from sw on); 1: held high; 2: held low;
    // 3: single one-sample pulse at w=p1. w=1 is the sample taken at the GATE-entry edge.
    function automatic bit wave(input int mode, input int w, input int p1, input int p2, input int sw);
        case (mode)
            0:       return (w < sw) ? ((w % p1) >= p1 / 2) : (((w - sw) % p2) >= p2 / 2);
            1:       return 1'b1;
            2:       return 1'b0;
            default: return (w == p1);
        endcase
    endfunction

    int vf[8], vh[8], vc[8];
    int nv, c0, busy_lo;

    // Called at a negedge with the DUT idle; raises en together with the first wave sample.
    task automatic run_wave(input int mode, input int ncyc, input int p1, input int p2, input int sw);
        nv      = 0;
        busy_lo = 0;
        c0      = 0;
        for (int i = 0; i < 8; i++) begin
            vf[i] = -1;
            vh[i] = -1;
            vc[i] = -1;
        end
        for (int w = 1; w <= ncyc; w++) begin
            sig_in = wave(mode, w, p1, p2, sw);
            en     = 1'b1;
            @(negedge clk);
            if (w == 1) c0 = cyc;
            if (freq_valid && nv < 8) begin
                vf[nv] = int'(freq_out);
                vh[nv] = int'(high_out);
                vc[nv] = cyc;
                nv++;
            end
            if (!busy) busy_lo++;
        end
    endtask

    task automatic idle(input int n);
        en     = 1'b0;
        sig_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                total++;
                if (freq_out !== W'(m_freq) || high_out !== W'(m_high) ||
                    freq_valid !== m_vld || busy !== m_busy) begin
                    bad++;
                    $display("FAIL model cyc=%0d: dut f=%0d h=%0d v=%0b b=%0b want f=%0d h=%0d v=%0b b=%0b",
                             cyc, freq_out, high_out, freq_valid, busy, m_freq, m_high, m_vld, m_busy);
                end
            end
        join_none

        #2 rst_n = 1'b0;
        #1;
        chk("rst_freq", freq_out, 0);
        chk("rst_high", high_out, 0);
        chk("rst_vld", freq_valid, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // Rise in gate cycle 999 belongs to that window; one cycle later it belongs to the next.
        run_wave(3, 2005, 999, 0, 0);
        chk("edge999_w1_freq", vf[0], 1);
        chk("edge999_w1_high", vh[0], 1);
        chk("edge999_w2_freq", vf[1], 0);
        idle(5);
        run_wave(3, 2005, 1000, 0, 0);
        chk("edge1000_w1_freq", vf[0], 0);
        chk("edge1000_w2_freq", vf[1], 1);
        chk("edge1000_w2_high", vh[1], 1);
        idle(5);

        run_wave(1, 2005, 10, 10, 0);
        chk("held1_freq", vf[1], 0);
        chk("held1_high", vh[1], 1000);
        idle(5);
        run_wave(2, 2005, 10, 10, 0);
        chk("held0_freq", vf[1], 0);
        chk("held0_high", vh[1], 0);
        idle(5);

        run_wave(0, 3005, 10, 10, 100000);
        chk("sq_count", nv, 3);
        chk("sq_first_lat", vc[0] - c0, 1000);
        chk("sq_w2_freq", vf[1], 100);
        chk("sq_w2_high", vh[1], 500);
        chk("sq_w3_freq", vf[2], 100);
        chk("sq_w3_high", vh[2], 500);
        chk("sq_period", vc[1] - vc[0], 1000);
        idle(5);

        // Abort after 600 cycles: results from the previous window must survive.
        run_wave(1, 600, 10, 10, 0);
        chk("abort_no_vld", nv, 0);
        en     = 1'b0;
        sig_in = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_vld", freq_valid, 0);
        chk("abort_freq", freq_out, 100);
        chk("abort_high", high_out, 500);
        idle(3);
        run_wave(0, 1005, 10, 10, 100000);
        chk("reen_lat", vc[0] - c0, 1000);
        chk("reen_freq", vf[0], 100);
        chk("reen_high", vh[0], 500);
        idle(5);

        // Asynchronous reset 400 cycles into a window.
        run_wave(0, 400, 10, 10, 100000);
        #3 rst_n = 1'b0;
        #1;
        chk("rstmid_freq", freq_out, 0);
        chk("rstmid_high", high_out, 0);
        chk("rstmid_vld", freq_valid, 0);
        chk("rstmid_busy", busy, 0);
        en     = 1'b0;
        sig_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #3 rst_n = 1'b1;
        run_wave(0, 1005, 10, 10, 100000);
        chk("rstmid_lat", vc[0] - c0, 1000);
        chk("rstmid_new_freq", vf[0], 100);
        idle(5);

        // Back-to-back windows, period 10 -> 20 at the second window start.
        run_wave(0, 3005, 10, 20, 1000);
        chk("b2b_count", nv, 3);
        chk("b2b_w1_freq", vf[0], 100);
        chk("b2b_w2_freq", vf[1], 50);
        chk("b2b_w2_high", vh[1], 500);
        chk("b2b_w3_freq", vf[2], 50);
        chk("b2b_gap1", vc[1] - vc[0], 1000);
        chk("b2b_gap2", vc[2] - vc[1], 1000);
        chk("b2b_busy_low", busy_lo, 0);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
Gated frequency and duty-cycle meter: counts rising edges and high-time of an asynchronous input over a fixed window of system-clock cycles. It is the measuring counterpart of the team's clock dividers and is used to check divider outputs and external tick sources on the 50 MHz board clock. Results go to display and debug logic with a one-cycle valid strobe.

Parameters:
GATE_CYCLES, 50000000, gate window length in clk cycles (1 s at 50 MHz); legal range >= 2
CNT_W, 28, width of the edge and high-time result counters; must satisfy 2^CNT_W > GATE_CYCLES

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  reset, asynchronous, active-low
en  input  1  measurement enable, level-sensitive; synchronous to clk
sig_in  input  1  signal under test, asynchronous to clk
freq_out  output  CNT_W  rising edges counted in the last completed window
high_out  output  CNT_W  clk cycles sig was high in the last completed window
freq_valid  output  1  one-cycle pulse when freq_out/high_out update
busy  output  1  high while a window is in progress

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. Sync flops, gate counter, edge counter, high counter, freq_out, high_out, freq_valid and busy all go to 0.
- Input conditioning: sig_in passes through 2-flop synchronizer s1->s2 and a third flop s3. rise = s2 & ~s3 (combinational). sig = s2. An edge on sig_in is seen as rise 2-3 clk later.
- States: IDLE, GATE. busy=1 exactly when state==GATE, registered.
- IDLE: if en=1 at a clk edge, go to GATE. Clear gate counter, edge counter and high counter.
- GATE, each cycle: gate_cnt += 1. If rise, edge_cnt += 1. If sig, high_cnt += 1. The cycle that enters GATE is gate cycle 0 and is counted.
- Window end: the cycle where gate_cnt == GATE_CYCLES-1 is the final counted cycle, including its rise/sig contribution.
- At the clk edge ending the final cycle:
  - freq_out <= final edge count; high_out <= final high count.
  - freq_valid <= 1 for exactly one cycle.
  - If en=1, restart immediately with counters cleared and state GATE, leaving no gap cycle. The next window's cycle 0 is the cycle where freq_valid=1.
  - If en=0, go to IDLE.
- Abort: en=0 sampled in GATE before the final cycle -> IDLE next edge, partial counts discarded. freq_out/high_out hold previous values; no freq_valid.
- Counter widths: gate counter is clog2(GATE_CYCLES) bits. Edge and high counters are CNT_W bits. The CNT_W constraint guarantees no overflow, so no saturation logic is required.
- Outputs are registered. freq_out/high_out change only on freq_valid cycles or reset.
- Reset mid-window: immediate return to reset values, and the partial window is lost.
- Sig already high at window start: no rise is counted for it; high_cnt counts from cycle 0.

Test Plan:
- GATE_CYCLES=1000; sig_in = 50% square wave, period 10 clk, phase-locked; en held 1 -> freq_valid every 1000 cycles, freq_out=100, high_out=500 from the second window on.
- sig_in held 1 for the whole run, en=1 -> freq_out=0, high_out=1000; sig_in held 0 -> freq_out=0, high_out=0.
- Boundary edge: single sig_in pulse timed so rise occurs in gate cycle 999 -> counted in that window (freq_out=1). Timed one cycle later -> counted in the next window.
- Abort: en=1 for 600 cycles then 0 -> busy drops next edge, no freq_valid, freq_out/high_out unchanged from prior window. Re-raise en -> full fresh window of 1000 cycles.
- Reset mid-window: rst_n pulsed low asynchronously (between clk edges) at cycle 400 -> all outputs 0 immediately. With en=1 after release, the first freq_valid arrives 1000 cycles after GATE entry.
- Back-to-back: en=1 continuously for 3 windows with period changed 10->20 clk at the window-2 start -> freq_out sequence 100, 50, 50; busy never deasserts; freq_valid pulses exactly 1000 cycles apart.
